// File: rtl/multichannel_delay_line_pkg.sv
// Shared types for the multichannel delay line: output source selection per channel.
package multichannel_delay_line_pkg;

    // Where a channel's registered output comes from after an enable.
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_BYPASS = 2'd1,
        SEL_RAM    = 2'd2
    } out_sel_e;

endpackage

// File: rtl/multichannel_delay_line_channel.sv
// One delay channel: ring RAM, saturating length register, read-address math, valid compare.
// Latency L enables (L=1 -> next edge); no backpressure, every enable is consumed.
module multichannel_delay_line_channel
    import multichannel_delay_line_pkg::*;
#(
    parameter int MAX_LENGTH = 32,
    parameter int BIT_WIDTH  = 16,
    localparam int ADDR_W    = $clog2(MAX_LENGTH),
    localparam int LEN_W     = ADDR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 length_load,
    input  logic [LEN_W-1:0]     length_in,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic [ADDR_W-1:0]    wptr,
    input  logic [ADDR_W-1:0]    fill,
    output logic [BIT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    output logic [LEN_W-1:0]     length_active
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LENGTH);

    logic [BIT_WIDTH-1:0] mem [MAX_LENGTH];
    logic [BIT_WIDTH-1:0] ram_q;
    logic [BIT_WIDTH-1:0] byp_q;
    out_sel_e             sel;
    logic [LEN_W-1:0]     len_sat;
    logic [LEN_W-1:0]     len_m1;
    logic [ADDR_W-1:0]    raddr;
    logic                 vld_next;
    logic                 advance;

    assign advance  = enable && !clear;
    assign len_sat  = (length_in > MAX_L) ? MAX_L : length_in;
    assign len_m1   = length_active - LEN_W'(1);
    assign raddr    = wptr - len_m1[ADDR_W-1:0];
    assign vld_next = (length_active != '0) && ({1'b0, fill} >= len_m1);

    // RAM and data holding registers carry no reset so the array maps onto block RAM;
    // the non-blocking read returns the pre-write content at the same address.
    always_ff @(posedge clock) begin
        if (advance) begin
            mem[wptr] <= data_in;
            ram_q     <= mem[raddr];
            byp_q     <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            length_active  <= LEN_W'(1);
            sel            <= SEL_ZERO;
            data_out_valid <= 1'b0;
        end else begin
            if (length_load) begin
                length_active <= len_sat;
            end
            if (clear) begin
                sel            <= SEL_ZERO;
                data_out_valid <= 1'b0;
            end else if (enable) begin
                data_out_valid <= vld_next;
                if (length_active == '0) begin
                    sel <= SEL_ZERO;
                end else if (length_active == LEN_W'(1)) begin
                    sel <= SEL_BYPASS;
                end else begin
                    sel <= SEL_RAM;
                end
            end
        end
    end

    // Output is a select between registered sources; reset/clear force the zero leg.
    always_comb begin
        data_out = '0;
        case (sel)
            SEL_BYPASS: data_out = byp_q;
            SEL_RAM:    data_out = ram_q;
            default:    data_out = '0;
        endcase
    end

endmodule

// File: rtl/multichannel_delay_line.sv
// N-channel programmable sample delay with shared write pointer and fill tracking.
// Latency L_c enables per channel; no backpressure, sample strobe is always accepted.
module multichannel_delay_line
    import multichannel_delay_line_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int MAX_LENGTH = 32,
    parameter int BIT_WIDTH  = 16,
    localparam int ADDR_W    = $clog2(MAX_LENGTH),
    localparam int LEN_W     = ADDR_W + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          length_load,
    input  logic [CHANNELS*LEN_W-1:0]     length_in,
    input  logic [CHANNELS*BIT_WIDTH-1:0] data_in,
    output logic [CHANNELS*BIT_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]           data_out_valid,
    output logic [CHANNELS*LEN_W-1:0]     length_active
);

    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(MAX_LENGTH - 1);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] fill;

    // Fill stops at MAX_LENGTH-1, enough to qualify the longest delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            fill <= '0;
        end else if (clear) begin
            wptr <= '0;
            fill <= '0;
        end else if (enable) begin
            wptr <= wptr + ADDR_W'(1);
            if (fill != FILL_MAX) begin
                fill <= fill + ADDR_W'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        multichannel_delay_line_channel #(
            .MAX_LENGTH (MAX_LENGTH),
            .BIT_WIDTH  (BIT_WIDTH)
        ) u_channel (
            .clock          (clock),
            .reset_n        (reset_n),
            .clear          (clear),
            .enable         (enable),
            .length_load    (length_load),
            .length_in      (length_in[c*LEN_W +: LEN_W]),
            .data_in        (data_in[c*BIT_WIDTH +: BIT_WIDTH]),
            .wptr           (wptr),
            .fill           (fill),
            .data_out       (data_out[c*BIT_WIDTH +: BIT_WIDTH]),
            .data_out_valid (data_out_valid[c]),
            .length_active  (length_active[c*LEN_W +: LEN_W])
        );
    end

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Directed bench with a scoreboard queue fed by a behavioural history model.
module tb_multichannel_delay_line;

    localparam int CH = 4;
    localparam int ML = 32;
    localparam int BW = 16;
    localparam int LW = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              clear = 1'b0;
    logic              enable = 1'b0;
    logic              length_load = 1'b0;
    logic [CH*LW-1:0]  length_in = '0;
    logic [CH*BW-1:0]  data_in = '0;
    logic [CH*BW-1:0]  data_out;
    logic [CH-1:0]     data_out_valid;
    logic [CH*LW-1:0]  length_active;

    multichannel_delay_line #(
        .CHANNELS   (CH),
        .MAX_LENGTH (ML),
        .BIT_WIDTH  (BW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clear          (clear),
        .enable         (enable),
        .length_load    (length_load),
        .length_in      (length_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .length_active  (length_active)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CH*BW-1:0] dat;
        logic [CH-1:0]    vld;
        logic [CH-1:0]    known;
        logic [CH*LW-1:0] len;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    logic [BW-1:0] hist [CH][512];
    int            wr_cnt;
    int            len_m [CH];
    int            ld_len [CH];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH*LW-1:0] pack_len();
        logic [CH*LW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*LW +: LW] = LW'(len_m[c]);
        return r;
    endfunction

    task automatic model_reset();
        wr_cnt = 0;
        for (int c = 0; c < CH; c++) len_m[c] = 1;
        cur.dat   = '0;
        cur.vld   = '0;
        cur.known = '1;
        cur.len   = pack_len();
    endtask

    task automatic step(input bit en, input bit clr, input bit ld, input int base);
        exp_t e;
        int   l;
        enable      = en;
        clear       = clr;
        length_load = ld;
        for (int c = 0; c < CH; c++) begin
            length_in[c*LW +: LW] = LW'(ld_len[c]);
            data_in[c*BW +: BW]   = BW'(base + c * 256);
        end
        if (clr) begin
            cur.dat   = '0;
            cur.vld   = '0;
            cur.known = '1;
            wr_cnt    = 0;
        end else if (en) begin
            for (int c = 0; c < CH; c++) begin
                l = len_m[c];
                hist[c][wr_cnt] = data_in[c*BW +: BW];
                cur.vld[c]   = (l != 0) && (wr_cnt >= l - 1);
                cur.known[c] = (l == 0) || cur.vld[c];
                cur.dat[c*BW +: BW] = '0;
                if (cur.vld[c]) cur.dat[c*BW +: BW] = hist[c][wr_cnt - (l - 1)];
            end
            wr_cnt++;
        end
        if (ld) begin
            for (int c = 0; c < CH; c++) len_m[c] = (ld_len[c] > ML) ? ML : ld_len[c];
        end
        cur.len = pack_len();
        sb.push_back(cur);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        for (int c = 0; c < CH; c++) begin
            if (e.known[c]) chk($sformatf("data_ch%0d", c), 64'(data_out[c*BW +: BW]), 64'(e.dat[c*BW +: BW]));
        end
        chk("valid", 64'(data_out_valid), 64'(e.vld));
        chk("length_active", 64'(length_active), 64'(e.len));
        enable      = 1'b0;
        clear       = 1'b0;
        length_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ld_len = '{1, 1, 1, 1};
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_data", 64'(data_out), 64'(0));
        chk("reset_valid", 64'(data_out_valid), 64'(0));
        chk("reset_len", 64'(length_active), 64'(pack_len()));
        reset_n = 1'b1;

        // L=1 on every channel: one-edge latency, valid from the first sample.
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        step(1, 0, 0, 3);

        // Mixed lengths incl. MAX, loaded together with a clear; ramp past two wraps with gaps.
        ld_len = '{5, 1, 32, 3};
        step(0, 1, 1, 0);
        for (int n = 0; n < 72; n++) begin
            if (n % 9 == 4) step(0, 0, 0, 999);
            step(1, 0, 0, n);
        end

        // Saturation of an oversize length and the zero-length channel.
        ld_len = '{40, 0, 32, 2};
        step(0, 0, 1, 0);
        for (int n = 0; n < 6; n++) step(1, 0, 0, 500 + n);

        // Length 3 -> 8 with a simultaneous enable: that enable still uses 3.
        ld_len = '{3, 3, 3, 3};
        step(0, 1, 1, 0);
        for (int n = 0; n < 20; n++) step(1, 0, 0, n);
        ld_len = '{8, 8, 8, 8};
        step(1, 0, 1, 20);
        for (int n = 21; n < 30; n++) step(1, 0, 0, n);

        // Clear beats a simultaneous enable; valid returns on the 4th enable after it.
        ld_len = '{4, 4, 4, 4};
        step(0, 1, 1, 0);
        for (int n = 0; n < 10; n++) step(1, 0, 0, n);
        step(1, 1, 0, 10);
        for (int n = 11; n < 17; n++) step(1, 0, 0, n);

        // Asynchronous reset between clock edges zeroes outputs without a clock.
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_data", 64'(data_out), 64'(0));
        chk("async_rst_valid", 64'(data_out_valid), 64'(0));
        chk("async_rst_len", 64'(length_active), 64'(pack_len()));
        @(negedge clock);
        reset_n = 1'b1;
        ld_len = '{1, 1, 1, 1};
        step(1, 0, 0, 100);
        step(1, 0, 0, 101);
        step(0, 0, 0, 102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
